// File: rtl/bsg_gray_binary_pipe.sv
// Pipelined bidirectional Gray/binary converter with an elastic valid/ready -> valid/yumi
// pipeline and an optional Gray unit-distance step checker for pointer sanity checking.
module bsg_gray_binary_pipe #(
  parameter int width_p  = 16,
  parameter int stages_p = 2,
  parameter int check_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic               mode_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               mode_o,
  output logic               err_o,
  input  logic               yumi_i
);

  localparam int rows_lp           = $clog2(width_p);
  localparam int rows_per_stage_lp = (rows_lp + stages_p - 1) / stages_p;

  logic [stages_p-1:0] valid_reg;
  logic [stages_p-1:0] mode_reg;
  logic [stages_p-1:0] err_reg;
  logic [width_p-1:0]  data_reg [stages_p];

  logic [stages_p-1:0] adv;
  logic [stages_p-1:0] v_in;
  logic [stages_p-1:0] mode_in;
  logic [stages_p-1:0] err_in;
  logic [width_p-1:0]  word_in   [stages_p];
  logic [width_p-1:0]  word_next [stages_p];

  logic accept;
  logic chk_err;

  assign ready_o = adv[0];
  assign accept  = v_i & ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < stages_p; gi++) begin : g_stage
      localparam int lo_lp = gi * rows_per_stage_lp;
      localparam int hi_lp = ((gi + 1) * rows_per_stage_lp > rows_lp) ? rows_lp
                                                                       : (gi + 1) * rows_per_stage_lp;
      logic [width_p-1:0] x;

      // A stage can move when any stage from here to the output has a hole, or the output is taken.
      assign adv[gi] = yumi_i | ~(&valid_reg[stages_p-1:gi]);

      if (gi == 0) begin : g_first
        assign v_in[gi]    = v_i;
        assign mode_in[gi] = mode_i;
        assign err_in[gi]  = chk_err;
        assign word_in[gi] = data_i;
      end else begin : g_rest
        assign v_in[gi]    = valid_reg[gi-1];
        assign mode_in[gi] = mode_reg[gi-1];
        assign err_in[gi]  = err_reg[gi-1];
        assign word_in[gi] = data_reg[gi-1];
      end

      always_comb begin
        x = word_in[gi];
        if (mode_in[gi]) begin
          if (gi == 0) x = word_in[gi] ^ (word_in[gi] >> 1);
        end else begin
          for (int j = lo_lp; j < hi_lp; j++) x = x ^ (x >> (1 << j));
        end
      end

      assign word_next[gi] = x;
    end

    if (check_p != 0) begin : g_chk
      localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};
      logic [width_p-1:0] hist_reg;
      logic               hist_v_reg;
      logic [width_p-1:0] g;
      logic [width_p-1:0] diff;

      // In binary->Gray mode the stage-0 result is already the Gray value.
      assign g       = mode_i ? word_next[0] : data_i;
      assign diff    = g ^ hist_reg;
      assign chk_err = hist_v_reg & ~((diff != '0) & ((diff & (diff - one_lp)) == '0));

      always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
          hist_reg   <= '0;
          hist_v_reg <= 1'b0;
        end else if (accept) begin
          hist_reg   <= g;
          hist_v_reg <= 1'b1;
        end
      end
    end else begin : g_no_chk
      assign chk_err = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_reg <= '0;
      mode_reg  <= '0;
      err_reg   <= '0;
      for (int s = 0; s < stages_p; s++) data_reg[s] <= '0;
    end else begin
      for (int s = 0; s < stages_p; s++) begin
        if (adv[s]) begin
          valid_reg[s] <= v_in[s];
          if (v_in[s]) begin
            data_reg[s] <= word_next[s];
            mode_reg[s] <= mode_in[s];
            err_reg[s]  <= err_in[s];
          end
        end
      end
    end
  end

  assign v_o    = valid_reg[stages_p-1];
  assign data_o = data_reg[stages_p-1];
  assign mode_o = mode_reg[stages_p-1];
  assign err_o  = err_reg[stages_p-1] & valid_reg[stages_p-1];

  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (v_o || !yumi_i);
  end

endmodule

// File: tb/tb_bsg_gray_binary_pipe.sv
// Directed bench for bsg_gray_binary_pipe: a 16-bit/2-stage instance with hand-computed vectors
// and a 5-bit/3-stage instance swept over every input value against a scoreboard.
module tb_bsg_gray_binary_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v, ready, mode, vo, modeo, erro, yumi;
  logic [15:0] data, datao;
  logic        v5, ready5, mode5, vo5, modeo5, erro5, yumi5;
  logic [4:0]  data5, datao5;
  bit          yumi_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_gray_binary_pipe #(.width_p(16), .stages_p(2), .check_p(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_o(ready), .mode_i(mode),
    .data_i(data), .v_o(vo), .data_o(datao), .mode_o(modeo), .err_o(erro), .yumi_i(yumi)
  );

  bsg_gray_binary_pipe #(.width_p(5), .stages_p(3), .check_p(1)) dut5 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v5), .ready_o(ready5), .mode_i(mode5),
    .data_i(data5), .v_o(vo5), .data_o(datao5), .mode_o(modeo5), .err_o(erro5), .yumi_i(yumi5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    if (obs === exp) $display("[%0t] ok %s = %h", $time, tag, obs);
  endtask

  // Consumers only take a word that is being presented.
  task automatic cyc();
    yumi  = yumi_en && vo;
    yumi5 = vo5;
    @(posedge clk);
    #1;
    yumi  = yumi_en && vo;
    yumi5 = vo5;
  endtask

  task automatic set_yumi(input bit en);
    yumi_en = en;
    yumi    = yumi_en && vo;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    v = 1'b0; v5 = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  function automatic logic [4:0] g2b5(input logic [4:0] g);
    logic [4:0] b;
    for (int k = 0; k < 5; k++) b[k] = ^(g >> k);
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] in3  [5] = '{16'h0000, 16'h0001, 16'h0003, 16'h0003, 16'h0000};
    logic [15:0] exp3 [5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0002, 16'h0000};
    logic        err3 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [6:0]  sb [$];
    logic [6:0]  got;
    logic [4:0]  hist5, g5, d5;
    bit          hv5;
    bit          e5;
    int          sent;

    mode = 1'b0; data = '0; mode5 = 1'b0; data5 = '0;
    yumi = 1'b0; yumi5 = 1'b0; yumi_en = 1'b0;
    do_reset();

    // Reset state
    check("rst_v_o", vo, 0);
    check("rst_data_o", datao, 0);
    check("rst_err_o", erro, 0);
    check("rst_mode_o", modeo, 0);
    #1 check("rst_ready_o", ready, 1);

    // G->B back-to-back, output 2 cycles after acceptance
    set_yumi(1);
    v = 1; mode = 0; data = 16'hC000; cyc();
    check("t1_latency_v_o", vo, 0);
    data = 16'h8000; cyc();
    check("t1_w0_v", vo, 1);
    check("t1_w0_data", datao, 16'h8000);
    check("t1_w0_err", erro, 0);
    data = 16'h0001; cyc();
    check("t1_w1_data", datao, 16'hFFFF);
    check("t1_w1_err", erro, 0);
    v = 0; cyc();
    check("t1_w2_data", datao, 16'h0001);
    check("t1_w2_err", erro, 1);
    cyc();
    check("t1_drain_v", vo, 0);

    // Mixed modes back-to-back; history shared across modes
    do_reset(); set_yumi(1);
    v = 1; mode = 1; data = 16'h0005; cyc();
    mode = 0; data = 16'h0007; cyc();
    check("t2_b2g_data", datao, 16'h0007);
    check("t2_b2g_mode", modeo, 1);
    check("t2_b2g_err", erro, 0);
    v = 0; cyc();
    check("t2_g2b_data", datao, 16'h0005);
    check("t2_g2b_mode", modeo, 0);
    check("t2_g2b_err", erro, 1);

    // Checker sequence including a repeat and a two-bit step
    do_reset(); set_yumi(1);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin v = 1; mode = 0; data = in3[i]; end
      else v = 0;
      cyc();
      if (i >= 1) begin
        check($sformatf("t3_v_%0d", i-1), vo, 1);
        check($sformatf("t3_data_%0d", i-1), datao, exp3[i-1]);
        check($sformatf("t3_err_%0d", i-1), erro, err3[i-1]);
      end
    end

    // Backpressure: pipeline fills, output holds, then drains in order
    do_reset(); set_yumi(0);
    v = 1; mode = 0; data = 16'h0001;
    #1 check("t4_ready_a0", ready, 1);
    cyc();
    data = 16'h0003;
    #1 check("t4_ready_a1", ready, 1);
    cyc();
    data = 16'h0002;
    #1 check("t4_ready_full", ready, 0);
    check("t4_hold_v", vo, 1);
    check("t4_hold_data0", datao, 16'h0001);
    cyc();
    #1 check("t4_ready_still_full", ready, 0);
    check("t4_hold_data1", datao, 16'h0001);
    cyc();
    check("t4_hold_data2", datao, 16'h0001);
    set_yumi(1);
    #1 check("t4_ready_release", ready, 1);
    cyc();
    check("t4_out_b", datao, 16'h0002);
    data = 16'h0006; cyc();
    check("t4_out_c", datao, 16'h0003);
    v = 0; cyc();
    check("t4_out_d", datao, 16'h0004);
    check("t4_out_d_err", erro, 0);
    cyc();
    check("t4_drained", vo, 0);

    // Reset mid-flight drops words and history
    do_reset(); set_yumi(1);
    v = 1; mode = 0; data = 16'h0004; cyc();
    data = 16'h0003; reset_n = 0; cyc();
    reset_n = 1; v = 0;
    check("t5_post_rst_v", vo, 0);
    #1 check("t5_post_rst_ready", ready, 1);
    cyc();
    check("t5_no_ghost_v", vo, 0);
    v = 1; data = 16'h0001; cyc();
    v = 0; cyc();
    check("t5_new_v", vo, 1);
    check("t5_new_data", datao, 16'h0001);
    check("t5_new_err", erro, 0);
    cyc();
    check("t5_new_drain", vo, 0);

    // 5-bit, 3-stage: every value in both directions against a scoreboard
    do_reset();
    hv5 = 0; hist5 = '0; sent = 0;
    for (int c = 0; c < 80; c++) begin
      if (sent < 64) begin
        v5 = 1; mode5 = (sent >= 32); d5 = sent[4:0]; data5 = d5;
      end else v5 = 0;
      #1;
      if (v5 && ready5) begin
        g5 = mode5 ? (d5 ^ (d5 >> 1)) : d5;
        e5 = hv5 && ($countones(g5 ^ hist5) != 1);
        hist5 = g5; hv5 = 1;
        sb.push_back({mode5, e5, mode5 ? g5 : g2b5(d5)});
        sent++;
      end
      cyc();
      if (vo5) begin
        if (sb.size() == 0) check("w5_unexpected_v", vo5, 0);
        else begin
          got = sb.pop_front();
          check($sformatf("w5_word m%0d", got[6]), {modeo5, erro5, datao5}, got);
        end
      end
    end
    check("w5_all_sent", sent, 64);
    check("w5_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
